// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared encodings for the two-port RAM arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_arbiter_v_if.sv
// rtl/ram_arbiter_v_if.sv - requester ports and RAM-side bus of the arbiter
interface ram_arbiter_v_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_ack;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;
    logic              b_ack;

    logic [ADDR_W-1:0] bus_RAM_ADDRESS;
    logic [DATA_W-1:0] bus_RAM_DATA_IN;
    logic              wire_RW;
    logic [DATA_W-1:0] bus_RAM_DATA_OUT;
    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  bus_RAM_DATA_OUT,
        output a_rdata, a_ack, b_rdata, b_ack,
        output bus_RAM_ADDRESS, bus_RAM_DATA_IN, wire_RW, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output bus_RAM_DATA_OUT,
        input  a_rdata, a_ack, b_rdata, b_ack,
        input  bus_RAM_ADDRESS, bus_RAM_DATA_IN, wire_RW, busy
    );

endinterface

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational winner select, A priority with starvation guard
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int CNT_W       = 3,
    parameter int MAX_A_BURST = 4
) (
    input  logic             a_req,
    input  logic             b_req,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             grant,
    output logic             winner
);

    always_comb begin
        grant  = a_req | b_req;
        winner = PORT_A;
        // B wins when alone, or when A has used up its burst while B waited
        if (b_req && (!a_req || (burst_cnt == CNT_W'(MAX_A_BURST)))) begin
            winner = PORT_B;
        end
    end

endmodule

// File: rtl/ram_arbiter_v.sv
// rtl/ram_arbiter_v.sv - shares one single-port RAM between requesters A (priority) and B
module ram_arbiter_v
    import ram_arb_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_A_BURST = 4
) (
    input  logic            clock,
    input  logic            reset,
    ram_arbiter_v_if.slave  bus
);

    localparam int         CNT_W    = $clog2(MAX_A_BURST + 1);
    localparam logic [1:0] LAT_INIT = 2'(RAM_LATENCY - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [CNT_W-1:0]  burst_cnt;
    logic [1:0]        lat_cnt;
    logic              sel_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              a_ack_q;
    logic              b_ack_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic              grant;
    logic              winner;

    ram_arb_pick #(
        .CNT_W       (CNT_W),
        .MAX_A_BURST (MAX_A_BURST)
    ) u_pick (
        .a_req     (bus.a_req),
        .b_req     (bus.b_req),
        .burst_cnt (burst_cnt),
        .grant     (grant),
        .winner    (winner)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (grant) state_next = ST_ACCESS;
            ST_ACCESS: state_next = (RAM_LATENCY == 1) ? ST_DONE : ST_WAIT;
            ST_WAIT:   if (lat_cnt <= 2'd1) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            lat_cnt   <= '0;
            sel_port  <= PORT_A;
            sel_we    <= RW_READ;
            sel_addr  <= '0;
            sel_wdata <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state   <= state_next;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        sel_port <= winner;
                        if (winner == PORT_A) begin
                            sel_we    <= bus.a_we;
                            sel_addr  <= bus.a_addr;
                            sel_wdata <= bus.a_wdata;
                            if (!bus.b_req) begin
                                burst_cnt <= '0;
                            end else if (burst_cnt != CNT_W'(MAX_A_BURST)) begin
                                burst_cnt <= burst_cnt + 1'b1;
                            end
                        end else begin
                            sel_we    <= bus.b_we;
                            sel_addr  <= bus.b_addr;
                            sel_wdata <= bus.b_wdata;
                            burst_cnt <= '0;
                        end
                    end
                end
                ST_ACCESS: lat_cnt <= LAT_INIT;
                ST_WAIT:   lat_cnt <= lat_cnt - 1'b1;
                ST_DONE: begin
                    // ack and read data become visible together in the following cycle
                    if (sel_port == PORT_A) begin
                        a_ack_q <= 1'b1;
                        if (sel_we == RW_READ) a_rdata_q <= bus.bus_RAM_DATA_OUT;
                    end else begin
                        b_ack_q <= 1'b1;
                        if (sel_we == RW_READ) b_rdata_q <= bus.bus_RAM_DATA_OUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // decoded from state so an async reset drops the strobe immediately
    assign bus.wire_RW         = ((state == ST_ACCESS) && (sel_we == RW_WRITE)) ? RW_WRITE : RW_READ;
    assign bus.bus_RAM_ADDRESS = sel_addr;
    assign bus.bus_RAM_DATA_IN = sel_wdata;
    assign bus.busy            = (state != ST_IDLE);
    assign bus.a_ack           = a_ack_q;
    assign bus.b_ack           = b_ack_q;
    assign bus.a_rdata         = a_rdata_q;
    assign bus.b_rdata         = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter_v.sv
// tb/tb_ram_arbiter_v.sv - scoreboard bench for ram_arbiter_v at RAM latency 1 and 3
module tb_ram_arbiter_v;

    typedef struct packed {
        logic        port;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    ram_arbiter_v_if #(.DATA_W(16), .ADDR_W(16)) if1 ();
    ram_arbiter_v_if #(.DATA_W(16), .ADDR_W(16)) if3 ();

    ram_arbiter_v #(.DATA_W(16), .ADDR_W(16), .RAM_LATENCY(1), .MAX_A_BURST(4)) dut1 (
        .clock (clk), .reset (rst1), .bus (if1.slave)
    );
    ram_arbiter_v #(.DATA_W(16), .ADDR_W(16), .RAM_LATENCY(3), .MAX_A_BURST(4)) dut3 (
        .clock (clk), .reset (rst3), .bus (if3.slave)
    );

    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [0:2];

    always @(posedge clk) begin
        if (pre_we) mem1[pre_addr] <= pre_data;
        else if (if1.wire_RW) mem1[if1.bus_RAM_ADDRESS[7:0]] <= if1.bus_RAM_DATA_IN;
        pipe1 <= mem1[if1.bus_RAM_ADDRESS[7:0]];
    end
    assign if1.bus_RAM_DATA_OUT = pipe1;

    always @(posedge clk) begin
        if (pre_we) mem3[pre_addr] <= pre_data;
        else if (if3.wire_RW) mem3[if3.bus_RAM_ADDRESS[7:0]] <= if3.bus_RAM_DATA_IN;
        pipe3[0] <= mem3[if3.bus_RAM_ADDRESS[7:0]];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign if3.bus_RAM_DATA_OUT = pipe3[2];

    // waits for the next ack; cyc counts negedges from the cycle the request was driven
    task automatic collect(input bit use3, input int limit, output int cyc,
                           output logic ga, output logic gb,
                           output logic [15:0] ra, output logic [15:0] rb, output int rw);
        cyc = -1; ga = 1'b0; gb = 1'b0; ra = '0; rb = '0; rw = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (use3) begin
                ga = if3.a_ack; gb = if3.b_ack; ra = if3.a_rdata; rb = if3.b_rdata;
                if (if3.wire_RW) rw++;
            end else begin
                ga = if1.a_ack; gb = if1.b_ack; ra = if1.a_rdata; rb = if1.b_rdata;
                if (if1.wire_RW) rw++;
            end
            if (ga || gb) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (if1.busy !== 1'b0 || if1.wire_RW !== 1'b0 || if1.a_ack !== 1'b0 ||
                if1.b_ack !== 1'b0 || if1.bus_RAM_ADDRESS !== 16'h0 ||
                if3.busy !== 1'b0 || if3.wire_RW !== 1'b0 || if3.a_ack !== 1'b0 ||
                if3.b_ack !== 1'b0 || if3.bus_RAM_ADDRESS !== 16'h0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d busy=%0b rw=%0b acks=%0b%0b addr=%h, required all zero",
                         i, if1.busy, if1.wire_RW, if1.a_ack, if1.b_ack, if1.bus_RAM_ADDRESS);
            end
        end
        checks++;
        if (if1.a_rdata !== 16'h0 || if1.b_rdata !== 16'h0 || if1.bus_RAM_DATA_IN !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs a_rdata=%h b_rdata=%h din=%h, required 0",
                     if1.a_rdata, if1.b_rdata, if1.bus_RAM_DATA_IN);
        end
    endtask

    task automatic test_write_read();
        int cyc; int rw; logic ga; logic gb; logic [15:0] ra; logic [15:0] rb; exp_t e;
        @(posedge clk); #1;
        if1.a_req = 1'b1; if1.a_we = 1'b1; if1.a_addr = 16'h0010; if1.a_wdata = 16'h1234;
        sb.push_back('{port: 1'b0, rd: 1'b0, data: 16'h0});
        collect(1'b0, 20, cyc, ga, gb, ra, rb, rw);
        if1.a_req = 1'b0; if1.a_wdata = 16'hFFFF;
        e = sb.pop_front();
        checks++;
        if (!(ga ^ gb) || gb !== e.port) begin
            errors++; $display("FAIL wr_ack got a=%0b b=%0b, required port %0d", ga, gb, e.port);
        end
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL wr_latency got %0d, required 3", cyc); end
        checks++;
        if (rw !== 1) begin errors++; $display("FAIL wr_pulses got %0d, required 1", rw); end

        @(posedge clk); #1;
        if1.a_req = 1'b1; if1.a_we = 1'b0; if1.a_addr = 16'h0010;
        sb.push_back('{port: 1'b0, rd: 1'b1, data: 16'h1234});
        collect(1'b0, 20, cyc, ga, gb, ra, rb, rw);
        if1.a_req = 1'b0; if1.a_addr = 16'h00AA;
        e = sb.pop_front();
        checks++;
        if (!(ga ^ gb) || gb !== e.port) begin
            errors++; $display("FAIL rd_ack got a=%0b b=%0b, required port %0d", ga, gb, e.port);
        end
        checks++;
        if (ra !== e.data) begin errors++; $display("FAIL rd_data got %h, required %h", ra, e.data); end
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL rd_latency got %0d, required 3", cyc); end
        checks++;
        if (rw !== 0) begin errors++; $display("FAIL rd_pulses got %0d, required 0", rw); end
        @(negedge clk);
        checks++;
        if (if1.a_ack !== 1'b0) begin errors++; $display("FAIL ack_width a_ack=%0b, required 0", if1.a_ack); end
        repeat (3) @(negedge clk);
        checks++;
        if (if1.a_rdata !== 16'h1234) begin
            errors++; $display("FAIL rdata_hold got %h, required 1234", if1.a_rdata);
        end
    endtask

    task automatic test_both_reads();
        int cyc; int rw; logic ga; logic gb; logic [15:0] ra; logic [15:0] rb; exp_t e;
        @(posedge clk); #1;
        if1.a_req = 1'b1; if1.a_we = 1'b0; if1.a_addr = 16'h0020;
        if1.b_req = 1'b1; if1.b_we = 1'b0; if1.b_addr = 16'h0030;
        sb.push_back('{port: 1'b0, rd: 1'b1, data: 16'h1111});
        sb.push_back('{port: 1'b1, rd: 1'b1, data: 16'h2222});
        for (int k = 0; k < 2; k++) begin
            collect(1'b0, 20, cyc, ga, gb, ra, rb, rw);
            if (ga) if1.a_req = 1'b0;
            if (gb) if1.b_req = 1'b0;
            e = sb.pop_front();
            checks++;
            if (!(ga ^ gb) || gb !== e.port) begin
                errors++; $display("FAIL both_order %0d got a=%0b b=%0b, required port %0d", k, ga, gb, e.port);
            end
            checks++;
            if ((gb ? rb : ra) !== e.data) begin
                errors++; $display("FAIL both_data %0d got %h, required %h", k, (gb ? rb : ra), e.data);
            end
        end
        if1.a_req = 1'b0; if1.b_req = 1'b0;
    endtask

    task automatic test_starvation();
        int cyc; int rw; logic ga; logic gb; logic [15:0] ra; logic [15:0] rb; exp_t e;
        @(posedge clk); #1;
        if1.a_req = 1'b1; if1.a_we = 1'b0; if1.a_addr = 16'h0020;
        if1.b_req = 1'b1; if1.b_we = 1'b0; if1.b_addr = 16'h0030;
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4) sb.push_back('{port: 1'b1, rd: 1'b1, data: 16'h2222});
            else              sb.push_back('{port: 1'b0, rd: 1'b1, data: 16'h1111});
        end
        for (int k = 0; k < 10; k++) begin
            collect(1'b0, 20, cyc, ga, gb, ra, rb, rw);
            e = sb.pop_front();
            checks++;
            if (!(ga ^ gb) || gb !== e.port) begin
                errors++; $display("FAIL burst_order %0d got a=%0b b=%0b, required port %0d", k, ga, gb, e.port);
            end
            checks++;
            if ((gb ? rb : ra) !== e.data) begin
                errors++; $display("FAIL burst_data %0d got %h, required %h", k, (gb ? rb : ra), e.data);
            end
        end
        if1.a_req = 1'b0; if1.b_req = 1'b0;
    endtask

    task automatic test_latency3();
        int cyc; int rw; logic ga; logic gb; logic [15:0] ra; logic [15:0] rb; exp_t e;
        @(posedge clk); #1;
        if3.b_req = 1'b1; if3.b_we = 1'b0; if3.b_addr = 16'h00FF;
        sb.push_back('{port: 1'b1, rd: 1'b1, data: 16'hBEEF});
        collect(1'b1, 20, cyc, ga, gb, ra, rb, rw);
        if3.b_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!(ga ^ gb) || gb !== e.port) begin
            errors++; $display("FAIL lat3_ack got a=%0b b=%0b, required port %0d", ga, gb, e.port);
        end
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL lat3_latency got %0d, required 5", cyc); end
        checks++;
        if (rb !== e.data) begin errors++; $display("FAIL lat3_data got %h, required %h", rb, e.data); end
    endtask

    task automatic test_reset_mid();
        int cyc; int rw; logic ga; logic gb; logic [15:0] ra; logic [15:0] rb; exp_t e;
        @(posedge clk); #1;
        if1.a_req = 1'b1; if1.a_we = 1'b1; if1.a_addr = 16'h0040; if1.a_wdata = 16'hDEAD;
        @(posedge clk); #1;
        checks++;
        if (if1.wire_RW !== 1'b1) begin errors++; $display("FAIL mid_access rw=%0b, required 1", if1.wire_RW); end
        rst1 = 1'b1;
        #1;
        checks++;
        if (if1.wire_RW !== 1'b0 || if1.busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset rw=%0b busy=%0b, required 0 0", if1.wire_RW, if1.busy);
        end
        if1.a_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (if1.a_ack !== 1'b0 || if1.b_ack !== 1'b0 || if1.busy !== 1'b0) begin
                errors++; $display("FAIL mid_noack cycle %0d a=%0b b=%0b busy=%0b, required 0",
                                   i, if1.a_ack, if1.b_ack, if1.busy);
            end
        end
        @(posedge clk); #1;
        if1.a_req = 1'b1; if1.a_we = 1'b0; if1.a_addr = 16'h0010;
        sb.push_back('{port: 1'b0, rd: 1'b1, data: 16'h1234});
        collect(1'b0, 20, cyc, ga, gb, ra, rb, rw);
        if1.a_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!(ga ^ gb) || gb !== e.port || cyc !== 3) begin
            errors++; $display("FAIL post_reset_ack got a=%0b b=%0b cyc=%0d, required port %0d cyc 3",
                               ga, gb, cyc, e.port);
        end
        checks++;
        if (ra !== e.data) begin errors++; $display("FAIL post_reset_data got %h, required %h", ra, e.data); end
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        if1.a_req = 1'b0; if1.a_we = 1'b0; if1.a_addr = '0; if1.a_wdata = '0;
        if1.b_req = 1'b0; if1.b_we = 1'b0; if1.b_addr = '0; if1.b_wdata = '0;
        if3.a_req = 1'b0; if3.a_we = 1'b0; if3.a_addr = '0; if3.a_wdata = '0;
        if3.b_req = 1'b0; if3.b_we = 1'b0; if3.b_addr = '0; if3.b_wdata = '0;
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = 8'h20; pre_data = 16'h1111;
        @(posedge clk); #1;
        pre_addr = 8'h30; pre_data = 16'h2222;
        @(posedge clk); #1;
        pre_addr = 8'hFF; pre_data = 16'hBEEF;
        @(posedge clk); #1;
        pre_we = 1'b0;
        @(posedge clk); #1;
        rst1 = 1'b0; rst3 = 1'b0;

        test_reset();
        test_write_read();
        test_both_reads();
        test_starvation();
        test_latency3();
        test_reset_mid();

        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain left %0d, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
